rr_index_arbiter: RTL and testbench

- Round-robin arbiter over 32 request lines.
- Issues one winner per transaction as a registered 5-bit binary index, using a valid/ready handshake.
- Sits directly upstream of the 5-to-32 decoder: the decoder turns `Grant_idx` back into a one-hot grant/enable vector for the selected requester.
- Fairness comes from a rotating priority pointer that advances past each accepted winner.

---
 rtl/rr_arb_pkg.sv | 25 ++
 rtl/rr_index_arbiter_if.sv | 36 +++
 rtl/rr_pick32.sv | 45 ++++
 rtl/rr_index_arbiter.sv | 88 ++++++++
 tb/tb_rr_index_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for the 32-way round-robin index arbiter
//
// Purpose : request/index widths, arbiter state encoding and a pointer
//           increment helper used by the arbiter top and its pick logic.
// Ports   : none (package).
package rr_arb_pkg;

  localparam int NUM_REQ = 32;
  localparam int IDX_W   = 5;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] req_t;

  // GRANT is encoded as 1 so the state flop is directly the valid flag.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Next index after idx; the 5-bit width gives the 31 -> 0 wrap for free.
  function automatic idx_t idx_next(input idx_t idx);
    return idx + idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_index_arbiter_if.sv
// rtl/rr_index_arbiter_if.sv - request/grant handshake bundle for the round-robin index arbiter
//
// Purpose : groups the request vector, grant handshake and debug pointer.
// Signals : Req_in      - 32-bit level-sensitive request vector
//           Grant_ready - downstream accepts the current grant
//           Grant_valid - Grant_idx carries a valid winner
//           Grant_idx   - 5-bit winning requester index
//           Ptr_out     - current rotating priority pointer (debug)
// Modports: slave  - arbiter side
//           master - requester/consumer side
interface rr_index_arbiter_if;
  import rr_arb_pkg::*;

  req_t Req_in;
  logic Grant_ready;
  logic Grant_valid;
  idx_t Grant_idx;
  idx_t Ptr_out;

  modport slave (
    input  Req_in,
    input  Grant_ready,
    output Grant_valid,
    output Grant_idx,
    output Ptr_out
  );

  modport master (
    output Req_in,
    output Grant_ready,
    input  Grant_valid,
    input  Grant_idx,
    input  Ptr_out
  );

endinterface

// File: rtl/rr_pick32.sv
// rtl/rr_pick32.sv - combinational round-robin pick over 32 requests
//
// Purpose : returns the first set request searching i_ptr, i_ptr+1, ... with
//           modulo-32 wrap.
// Ports   : i_req [31:0] - request vector
//           i_ptr [4:0]  - search start position
//           o_idx [4:0]  - winning index (meaningless when o_any = 0)
//           o_any        - at least one request is set
module rr_pick32
  import rr_arb_pkg::*;
(
  input  req_t i_req,
  input  idx_t i_ptr,
  output idx_t o_idx,
  output logic o_any
);

  req_t w_rot;
  idx_t w_ffs;

  // Rotate right by i_ptr: bit 0 of w_rot is the request at the pointer.
  // The index sum is 5 bits wide, so it wraps modulo 32 by construction.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = i_req[idx_t'(i) + i_ptr];
    end
  end

  // Lowest set bit of the rotated vector; scanning downward lets the
  // lowest hit overwrite any higher one.
  always_comb begin
    w_ffs = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_ffs = idx_t'(i);
      end
    end
  end

  // Undo the rotation; 5-bit addition wraps back into 0..31.
  assign o_idx = w_ffs + i_ptr;
  assign o_any = |i_req;

endmodule

// File: rtl/rr_index_arbiter.sv
// rtl/rr_index_arbiter.sv - 32-way round-robin arbiter issuing a registered 5-bit winner index
//
// Purpose : grants one requester per transaction over a valid/ready handshake.
//           A rotating pointer moves just past each accepted winner so that
//           continuously active requesters are served in turn.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - rr_index_arbiter_if.slave (Req_in, Grant_ready in;
//                   Grant_valid, Grant_idx, Ptr_out out, all registered)
module rr_index_arbiter
  import rr_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  rr_index_arbiter_if.slave   bus
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  idx_t       r_grant_idx;
  idx_t       w_grant_idx_nxt;
  idx_t       r_ptr;
  idx_t       w_ptr_nxt;

  logic       w_accept;
  idx_t       w_pick_ptr;
  idx_t       w_pick_idx;
  logic       w_pick_any;

  assign w_accept = (r_state == GRANT) && bus.Grant_ready;

  // On an accept the pick must already see the advanced pointer so the
  // next winner can be loaded in the same edge without a bubble.
  assign w_pick_ptr = w_accept ? idx_next(r_grant_idx) : r_ptr;

  rr_pick32 u_pick (
    .i_req (bus.Req_in),
    .i_ptr (w_pick_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant_idx <= '0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  // While a grant is outstanding without ready, nothing moves: request
  // changes are ignored and the grant is never withdrawn.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
    w_ptr_nxt       = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt     = GRANT;
          w_grant_idx_nxt = w_pick_idx;
        end
      end
      GRANT: begin
        if (w_accept) begin
          w_ptr_nxt = w_pick_ptr;
          if (w_pick_any) begin
            w_grant_idx_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.Grant_valid = (r_state == GRANT);
  assign bus.Grant_idx   = r_grant_idx;
  assign bus.Ptr_out     = r_ptr;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// tb/tb_rr_index_arbiter.sv - self-checking bench for rr_index_arbiter
module tb_rr_index_arbiter;
  import rr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_index_arbiter_if bus();

  rr_index_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: explicit wrap-around scan, independent of the DUT's rotate/ffs.
  logic       m_valid;
  logic [4:0] m_idx;
  logic [4:0] m_ptr;

  function automatic logic [5:0] model_pick(input logic [31:0] req, input logic [4:0] ptr);
    for (int k = 0; k < 32; k++) begin
      logic [4:0] j;
      j = 5'((int'(ptr) + k) % 32);
      if (req[j]) return {1'b1, j};
    end
    return 6'd0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 5'd0;
    m_ptr   = 5'd0;
  endtask

  task automatic model_advance(input logic [31:0] req, input logic ready);
    logic [5:0] p;
    if (!m_valid) begin
      p = model_pick(req, m_ptr);
      if (p[5]) begin
        m_valid = 1'b1;
        m_idx   = p[4:0];
      end
    end else if (ready) begin
      m_ptr = 5'((int'(m_idx) + 1) % 32);
      p = model_pick(req, m_ptr);
      if (p[5]) m_idx = p[4:0];
      else      m_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic       valid;
    logic [4:0] idx;
    logic [4:0] ptr;
  } exp_t;

  exp_t sb[$];

  // Drive one cycle of stimulus, queue the model's expectation, compare after the edge.
  task automatic step(input logic [31:0] req, input logic ready);
    exp_t e;
    bus.Req_in      = req;
    bus.Grant_ready = ready;
    model_advance(req, ready);
    e.valid = m_valid;
    e.idx   = m_idx;
    e.ptr   = m_ptr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_valid", 32'(bus.Grant_valid), 32'(e.valid));
    check("sb_idx",   32'(bus.Grant_idx),   32'(e.idx));
    check("sb_ptr",   32'(bus.Ptr_out),     32'(e.ptr));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] req;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_idx;
    logic [4:0]  exp_ptr;
  } vec_t;

  vec_t vecs[10];
  int   counts[32];
  logic [31:0] dec;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Rotation / wrap vectors starting from reset (Ptr=0, IDLE).
    vecs[0] = '{32'h8000_0011, 1'b0, 1'b1, 5'd0,  5'd0};
    vecs[1] = '{32'h8000_0011, 1'b1, 1'b1, 5'd4,  5'd1};
    vecs[2] = '{32'h8000_0011, 1'b1, 1'b1, 5'd31, 5'd5};
    vecs[3] = '{32'h8000_0011, 1'b1, 1'b1, 5'd0,  5'd0};
    vecs[4] = '{32'h8000_0011, 1'b1, 1'b1, 5'd4,  5'd1};
    vecs[5] = '{32'h8000_0011, 1'b1, 1'b1, 5'd31, 5'd5};
    vecs[6] = '{32'h0000_0000, 1'b0, 1'b1, 5'd31, 5'd5};
    vecs[7] = '{32'h0000_0000, 1'b1, 1'b0, 5'd31, 5'd0};
    vecs[8] = '{32'h0000_0000, 1'b1, 1'b0, 5'd31, 5'd0};
    vecs[9] = '{32'h0000_0003, 1'b0, 1'b1, 5'd0,  5'd0};

    // Reset with all requests asserted.
    bus.Req_in      = 32'hFFFF_FFFF;
    bus.Grant_ready = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(bus.Grant_valid), 32'd0);
    check("rst_idx",   32'(bus.Grant_idx),   32'd0);
    check("rst_ptr",   32'(bus.Ptr_out),     32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(bus.Grant_valid), 32'd0);
    rst_n = 1'b1;
    step(32'hFFFF_FFFF, 1'b0);
    check("post_rst_valid", 32'(bus.Grant_valid), 32'd1);
    check("post_rst_idx",   32'(bus.Grant_idx),   32'd0);

    // Table-driven rotation and drain.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].req, vecs[i].ready);
      check($sformatf("vec%0d_valid", i), 32'(bus.Grant_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_idx", i),   32'(bus.Grant_idx),   32'(vecs[i].exp_idx));
      check($sformatf("vec%0d_ptr", i),   32'(bus.Ptr_out),     32'(vecs[i].exp_ptr));
    end

    // Backpressure: grant 7 held while requests change.
    step(32'h0000_0080, 1'b1);
    check("bp_first_idx", 32'(bus.Grant_idx), 32'd7);
    for (int i = 0; i < 5; i++) begin
      step(32'h0000_0100, 1'b0);
      check("bp_hold_idx",   32'(bus.Grant_idx),   32'd7);
      check("bp_hold_valid", 32'(bus.Grant_valid), 32'd1);
    end
    step(32'h0000_0100, 1'b1);
    check("bp_accept_idx", 32'(bus.Grant_idx), 32'd8);
    check("bp_accept_ptr", 32'(bus.Ptr_out),   32'd8);

    // Wrap and drain: reach Ptr=31, win idx 1, then drain to IDLE.
    step(32'h4000_0000, 1'b1);
    check("wrap_idx30", 32'(bus.Grant_idx), 32'd30);
    step(32'h0000_0002, 1'b1);
    check("wrap_ptr31", 32'(bus.Ptr_out),   32'd31);
    check("wrap_idx1",  32'(bus.Grant_idx), 32'd1);
    step(32'h0000_0000, 1'b1);
    check("drain_ptr",   32'(bus.Ptr_out),     32'd2);
    check("drain_valid", 32'(bus.Grant_valid), 32'd0);

    // Asynchronous reset while grant 12 is outstanding.
    step(32'h0000_1000, 1'b0);
    check("ar_pre_idx", 32'(bus.Grant_idx), 32'd12);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar_valid", 32'(bus.Grant_valid), 32'd0);
    check("ar_idx",   32'(bus.Grant_idx),   32'd0);
    check("ar_ptr",   32'(bus.Ptr_out),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(32'h0000_1000, 1'b0);
    check("ar_post_idx",   32'(bus.Grant_idx),   32'd12);
    check("ar_post_valid", 32'(bus.Grant_valid), 32'd1);

    // Fairness: all requests held for 64 accepts.
    do_reset();
    for (int i = 0; i < 32; i++) counts[i] = 0;
    step(32'hFFFF_FFFF, 1'b0);
    for (int k = 1; k <= 64; k++) begin
      counts[bus.Grant_idx]++;
      step(32'hFFFF_FFFF, 1'b1);
      dec = 32'd1 << bus.Grant_idx;
      check("fair_order",  32'(bus.Grant_idx), 32'(k % 32));
      check("fair_onehot", dec, 32'd1 << (k % 32));
      check("fair_popcnt", 32'($countones(dec)), 32'd1);
    end
    for (int i = 0; i < 32; i++) begin
      check($sformatf("fair_count%0d", i), 32'(counts[i]), 32'd2);
    end

    // Randomized requests and backpressure against the model.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      logic [31:0] r;
      r = $urandom() & $urandom() & $urandom();
      if ($urandom_range(0, 7) == 0) r = 32'd0;
      step(r, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
